// File: rtl/zbt_arb_pkg.sv
// Shared types for the ZBT bank arbiter: default widths, requester ids and
// the latency-pipe entry that tracks each issued access.
package zbt_arb_pkg;

    localparam int ZBT_ADDR_W = 19;
    localparam int ZBT_DATA_W = 36;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_RD,
        REQ_CW,
        REQ_PW
    } req_id_e;

    typedef struct packed {
        logic                  valid;
        logic                  is_read;
        logic [ZBT_DATA_W-1:0] wdata;
    } pipe_entry_t;

endpackage

// File: rtl/zbt_arb_pipe.sv
// Latency pipe: RD_LAT+1 stages of issued accesses. The last stage drives the
// bank write data and tells the top when the bank read data is due.
module zbt_arb_pipe
    import zbt_arb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  pipe_entry_t           push,
    output logic [ZBT_DATA_W-1:0] mem_wdata,
    output logic                  rd_sample
);

    pipe_entry_t [RD_LAT:0] stage;

    // NOTE: the pipe is a handful of flops, not a RAM, so every stage is reset;
    // this is what drops in-flight reads on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage <= '0;
        end else begin
            stage[0] <= push;
            for (int i = 1; i <= RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign mem_wdata = (stage[RD_LAT].valid && !stage[RD_LAT].is_read) ? stage[RD_LAT].wdata : '0;
    assign rd_sample = stage[RD_LAT].valid && stage[RD_LAT].is_read;

endmodule

// File: rtl/zbt_arb.sv
// Single-port ZBT bank arbiter: display reads first, capture/processed writers
// round-robin. Define ZBT_ARB_STARVE_GUARD_EN to add the writer starvation guard.
module zbt_arb
    import zbt_arb_pkg::*;
#(
    parameter int ADDR_W   = ZBT_ADDR_W,
    parameter int DATA_W   = ZBT_DATA_W,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              cw_req,
    input  logic [ADDR_W-1:0] cw_addr,
    input  logic [DATA_W-1:0] cw_data,
    output logic              cw_ack,
    input  logic              pw_req,
    input  logic [ADDR_W-1:0] pw_addr,
    input  logic [DATA_W-1:0] pw_data,
    output logic              pw_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    req_id_e     grant;
    req_id_e     w_grant;
    req_id_e     last_w;
    pipe_entry_t push;
    logic        rd_sample;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_grant = REQ_NONE;
        if (cw_req && pw_req) begin
            w_grant = (last_w == REQ_PW) ? REQ_CW : REQ_PW;
        end else if (cw_req) begin
            w_grant = REQ_CW;
        end else if (pw_req) begin
            w_grant = REQ_PW;
        end
    end

`ifdef ZBT_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cw_wait;
    logic [CNT_W-1:0] pw_wait;
    logic             cw_starved;
    logic             pw_starved;

    assign cw_starved = cw_req && (cw_wait == CNT_W'(MAX_WAIT));
    assign pw_starved = pw_req && (pw_wait == CNT_W'(MAX_WAIT));

    always_comb begin
        grant = REQ_NONE;
        if (cw_starved && pw_starved) begin
            grant = w_grant;
        end else if (cw_starved) begin
            grant = REQ_CW;
        end else if (pw_starved) begin
            grant = REQ_PW;
        end else if (rd_req) begin
            grant = REQ_RD;
        end else begin
            grant = w_grant;
        end
    end

    // Counters saturate so a writer that loses a starved tie stays starved.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cw_wait <= '0;
            pw_wait <= '0;
        end else begin
            if (!cw_req || cw_ack)                   cw_wait <= '0;
            else if (cw_wait != CNT_W'(MAX_WAIT))    cw_wait <= cw_wait + 1'b1;
            if (!pw_req || pw_ack)                   pw_wait <= '0;
            else if (pw_wait != CNT_W'(MAX_WAIT))    pw_wait <= pw_wait + 1'b1;
        end
    end
`else
    always_comb begin
        grant = rd_req ? REQ_RD : w_grant;
    end
`endif

    assign rd_ack = (grant == REQ_RD);
    assign cw_ack = (grant == REQ_CW);
    assign pw_ack = (grant == REQ_PW);

    always_comb begin
        push         = '0;
        push.valid   = (grant != REQ_NONE);
        push.is_read = (grant == REQ_RD);
        if (grant == REQ_CW)      push.wdata = cw_data;
        else if (grant == REQ_PW) push.wdata = pw_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            mem_we   <= 1'b0;
            last_w   <= REQ_PW;
        end else begin
            mem_we <= (grant == REQ_CW) || (grant == REQ_PW);
            case (grant)
                REQ_RD: mem_addr <= rd_addr;
                REQ_CW: begin
                    mem_addr <= cw_addr;
                    last_w   <= REQ_CW;
                end
                REQ_PW: begin
                    mem_addr <= pw_addr;
                    last_w   <= REQ_PW;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_sample;
            rd_data  <= rd_sample ? mem_rdata : '0;
        end
    end

    zbt_arb_pipe #(
        .RD_LAT (RD_LAT)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .mem_wdata (mem_wdata),
        .rd_sample (rd_sample)
    );

endmodule

// File: doc/zbt_arb.md
# zbt_arb

Single-port arbiter for one ZBT SRAM bank, shared between the display read path and two writers: the capture path, which writes raw pixel pairs, and the edge-processing path, which writes processed pixel pairs with their delayed write address. It grants at most one access per clock and drives the bank address and write-enable. It also pipelines write data and read data to match the bank's fixed latency. It sits between the video/processing blocks and the ZBT pins.

## Interface
Parameters:
- ADDR_W, 19, bank word address width
- DATA_W, 36, word width (two 18-bit pixels)
- RD_LAT, 2, cycles from address presented on mem_addr to data on mem_rdata / required on mem_wdata
- MAX_WAIT, 15, writer wait limit for the starvation guard

Ports:
- clk  in  1  system clock; all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- rd_req  in  1  display read request
- rd_addr  in  ADDR_W  display read address
- rd_ack  out  1  read granted this cycle (combinational)
- rd_data  out  DATA_W  returned read word
- rd_valid  out  1  rd_data valid, one cycle per granted read
- cw_req / cw_addr / cw_data  in  1 / ADDR_W / DATA_W  capture write request
- cw_ack  out  1  capture write granted this cycle (combinational)
- pw_req / pw_addr / pw_data  in  1 / ADDR_W / DATA_W  processed-pixel write request
- pw_ack  out  1  processed write granted this cycle (combinational)
- mem_addr  out  ADDR_W  bank address
- mem_we  out  1  bank write enable, active-high
- mem_wdata  out  DATA_W  bank write data
- mem_rdata  in  DATA_W  bank read data

## Operation
- Requesters hold req, addr and data stable until they see ack. Ack and payload are consumed on the same edge.
- Priority: rd_req first. Writers share the remaining slots round-robin. A last_w flag records the most recent writer granted; when both writers request, the other writer wins. After reset, cw wins the first tie.
- Only one ack is high per cycle. With no request, the issue slot is idle: mem_we=0 and mem_addr holds its last value.
- Grant cycle T: mem_addr and mem_we are registered and valid at T+1.
- Write: data is registered into the pipe at T and driven on mem_wdata at T+1+RD_LAT. mem_wdata is 0 in cycles with no write.
- Read: mem_rdata is sampled at T+1+RD_LAT. rd_data and rd_valid are registered and valid at T+2+RD_LAT.
- Back-to-back mixed read/write accesses need no bubbles, since ZBT has no bus turnaround.
- Reset (asynchronous, at any time) clears everything:
  - outputs: mem_addr=0, mem_we=0, mem_wdata=0, rd_data=0, rd_valid=0
  - pipe cleared and last_w=pw, so cw wins the first tie
  - wait counters set to 0
  - In-flight reads are dropped. In-flight writes are not guaranteed to complete.

## Timing
- Ack: combinational from req, 0 cycles.
- Write: mem_we at T+1, mem_wdata at T+1+RD_LAT.
- Read: rd_valid at T+2+RD_LAT (T+4 with default RD_LAT).
- Throughput: 1 access per cycle.

## Configuration
- ZBT_ARB_STARVE_GUARD_EN defined:
  - Each writer has a wait counter, sized to hold MAX_WAIT.
  - The counter increments each cycle that req=1 and ack=0. It clears on ack or when req=0.
  - When a counter equals MAX_WAIT, that writer is granted over rd_req for one cycle and rd_ack=0 that cycle.
  - If both counters reach MAX_WAIT in the same cycle, the round-robin rule decides.
- Not defined: strict read priority, no counters. Writers may starve while rd_req is held high.

## Structure
- Package zbt_arb_pkg holds:
  - ADDR_W and DATA_W constants
  - requester-id enum: REQ_NONE, REQ_RD, REQ_CW, REQ_PW
  - pipe-entry struct {valid, is_read, wdata}
- Sub-module zbt_arb_pipe: an RD_LAT+1-stage shift register of pipe entries, asynchronously reset. It produces mem_wdata and the read-sample strobe.
- The top level contains the grant logic, last_w, the wait counters and the output registers.

## Test plan
- Single cw write, addr 0x00010, data 0x123456789: cw_ack at T; mem_we=1 with mem_addr=0x00010 at T+1; mem_wdata=0x123456789 at T+3.
- Single read, addr 0x00020, with the bank model returning 0xABCDE0123: rd_valid=1 at T+4, rd_data=0xABCDE0123 for exactly one cycle.
- cw_req and pw_req held for 6 cycles: acks alternate cw, pw, cw, pw, cw, pw. mem_wdata ordering matches the ack order.
- rd_req, cw_req and pw_req all held high, guard disabled: rd_ack every cycle, zero writer acks.
- Same stimulus with ZBT_ARB_STARVE_GUARD_EN, MAX_WAIT=15: cw_ack at cycle 15, pw_ack at cycle 16, rd_ack low in exactly those cycles.
- Reset asserted one cycle after a read grant: all outputs 0 immediately, and no rd_valid appears afterwards.
